ps2_scancode_decoder: RTL and testbench
=======================================

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000, CLK cycles a prefix may wait for the next byte.
REQ-003 CLK  in  1  single system clock; all logic on posedge CLK.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 CODE_VALID  in  1  one-cycle strobe: a received PS/2 byte is on CODE.
REQ-006 CODE  in  8  received scancode byte; sampled only when CODE_VALID=1.
REQ-007 CODE_ERR  in  1  qualifies CODE_VALID: frame failed start/stop/parity check.
REQ-008 ev_valid  out  1  high when the FIFO is not empty.
REQ-009 ev_data  out  10  FIFO head event {ext, brk, code[7:0]}.
REQ-010 ev_pop  in  1  consumer pops the head; ignored when ev_valid=0.
REQ-011 held  out  5  live key state {SPACE, RIGHT, LEFT, DOWN, UP}, 1 = pressed.
REQ-012 overflow  out  1  sticky: an event was dropped because the FIFO was full.
REQ-013 err_count  out  8  saturating count of CODE_ERR bytes.

Function
REQ-014 FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-015 IDLE: E0 -> EXT; F0 -> BRK; AA, FA, FE, 00 or FF -> discarded, stay IDLE; any other byte -> push {0,0,CODE}, stay IDLE.
REQ-016 EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte -> push {1,0,CODE}, go IDLE.
REQ-017 BRK: any byte other than E0/F0 -> push {0,1,CODE}, go IDLE; E0 or F0 -> go IDLE, no push.
REQ-018 EXT_BRK: any byte other than E0/F0 -> push {1,1,CODE}, go IDLE; E0 or F0 -> go IDLE, no push.
REQ-019 CODE_VALID with CODE_ERR=1: no push, FSM -> IDLE, err_count += 1, saturating at 8'hFF.
REQ-020 Timeout counter: clears on every CODE_VALID and in IDLE; counts in other states; reaching TIMEOUT forces IDLE without a push.
REQ-021 Push latency: event enters the FIFO on the CLK edge that samples CODE_VALID; ev_valid is high the next cycle.
REQ-022 held updates on the same edge as the push; the make event sets the bit and the break event clears it.
REQ-023 held bit map: UP = {ext=1, code=75}; DOWN = {1,72}; LEFT = {1,6B}; RIGHT = {1,74}; SPACE = {0,29}; codes with the wrong ext flag do not affect held.
REQ-024 held updates even when the FIFO push is dropped for full.
REQ-025 FIFO is first-word fall-through; ev_data is valid whenever ev_valid=1; ev_pop removes the head at the edge.
REQ-026 Full and push without pop: event dropped, overflow <= 1, existing contents unchanged.
REQ-027 Full and push with pop in the same cycle: both occur; occupancy unchanged; no overflow.
REQ-028 Empty and push with pop in the same cycle: pop ignored; push stored.
REQ-029 Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty derive from the MSB comparison.

Reset
REQ-030 RST=1 at an edge: FSM -> IDLE; timeout counter, FIFO pointers, held, overflow and err_count -> 0; ev_valid=0.
REQ-031 RST takes priority over CODE_VALID in the same cycle; that byte is lost.
REQ-032 RST asserted mid-sequence (e.g., after E0) discards the partial prefix; the next non-prefix byte decodes as non-extended.

Verification
REQ-033 Bytes 29 then F0,29 (CODE_ERR=0, bytes 20 cycles apart), no pops -> FIFO holds 0x029 then 0x129; held[4] goes 1 then 0.
REQ-034 Bytes E0,75 then E0,F0,75 -> events 0x275 then 0x375; held[0] goes 1 then 0; bare 75 -> event 0x075, held unchanged.
REQ-035 Five make codes 1C,32,21,23,24 with no pops, FIFO_DEPTH=4 -> four events kept, 24 dropped, overflow=1; then pop+push on the same cycle while full -> occupancy stays 4.
REQ-036 E0 followed by TIMEOUT idle cycles, then 6B -> event 0x06B (non-extended); held[2] unchanged.
REQ-037 E0 with CODE_ERR=1, then 74 -> err_count=1, event 0x074; 300 error bytes -> err_count=8'hFF.
REQ-038 RST pulse one cycle after E0, then 72 -> event 0x072, held=0, overflow=0.

Source files
------------

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / event-out bus of the PS/2 scancode decoder.
// The master side supplies received bytes and pops events; the slave side is the decoder.
interface ps2_scancode_decoder_if;
    logic       CODE_VALID;
    logic [7:0] CODE;
    logic       CODE_ERR;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       ev_pop;

    modport master (
        output CODE_VALID, CODE, CODE_ERR, ev_pop,
        input  ev_valid, ev_data
    );

    modport slave (
        input  CODE_VALID, CODE, CODE_ERR, ev_pop,
        output ev_valid, ev_data
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: prefix FSM, arrow/space held state and a
// first-word-fall-through event FIFO of {ext, brk, code}.
//
// state     | meaning
// S_IDLE    | no prefix pending
// S_EXT     | E0 seen, waiting for code or F0
// S_BRK     | F0 seen, waiting for released code
// S_EXT_BRK | E0 F0 seen, waiting for released extended code
module ps2_scancode_decoder #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic                        CLK,
    input  logic                        RST,
    ps2_scancode_decoder_if.slave       bus,
    output logic [4:0]                  held,
    output logic                        overflow,
    output logic [7:0]                  err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [15:0] tmr_cnt;
    logic        timeout_hit;
    logic        push_req;
    logic [9:0]  push_ev;
    logic        is_prefix, is_ignored;
    logic [4:0]  key_hit;

    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, pop_eff, push_eff;

    assign is_prefix  = (bus.CODE == 8'hE0) || (bus.CODE == 8'hF0);
    assign is_ignored = (bus.CODE == 8'hAA) || (bus.CODE == 8'hFA) || (bus.CODE == 8'hFE) ||
                        (bus.CODE == 8'h00) || (bus.CODE == 8'hFF);

    assign timeout_hit = !bus.CODE_VALID && (state != S_IDLE) && (tmr_cnt == TIMEOUT - 16'd1);

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        push_ev   = '0;
        if (bus.CODE_VALID) begin
            if (bus.CODE_ERR) begin
                state_nxt = S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.CODE == 8'hE0)      state_nxt = S_EXT;
                        else if (bus.CODE == 8'hF0) state_nxt = S_BRK;
                        else if (!is_ignored) begin
                            push_req = 1'b1;
                            push_ev  = {2'b00, bus.CODE};
                        end
                    end
                    S_EXT: begin
                        if (bus.CODE == 8'hF0)      state_nxt = S_EXT_BRK;
                        else if (bus.CODE != 8'hE0) begin
                            state_nxt = S_IDLE;
                            push_req  = 1'b1;
                            push_ev   = {2'b10, bus.CODE};
                        end
                    end
                    S_BRK: begin
                        state_nxt = S_IDLE;
                        push_req  = !is_prefix;
                        push_ev   = {2'b01, bus.CODE};
                    end
                    default: begin
                        state_nxt = S_IDLE;
                        push_req  = !is_prefix;
                        push_ev   = {2'b11, bus.CODE};
                    end
                endcase
            end
        end else if (timeout_hit) begin
            state_nxt = S_IDLE;
        end
    end

    // One-hot held bit touched by the event being decoded: {SPACE, RIGHT, LEFT, DOWN, UP}
    always_comb begin
        key_hit = '0;
        if (push_ev[9]) begin
            key_hit[0] = (push_ev[7:0] == 8'h75);
            key_hit[1] = (push_ev[7:0] == 8'h72);
            key_hit[2] = (push_ev[7:0] == 8'h6B);
            key_hit[3] = (push_ev[7:0] == 8'h74);
        end else begin
            key_hit[4] = (push_ev[7:0] == 8'h29);
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_eff    = bus.ev_pop && !fifo_empty;
    assign push_eff   = push_req && (!fifo_full || pop_eff);

    assign bus.ev_valid = !fifo_empty;
    assign bus.ev_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            tmr_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            held      <= '0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            if (bus.CODE_VALID || state == S_IDLE || timeout_hit) tmr_cnt <= '0;
            else                                                  tmr_cnt <= tmr_cnt + 16'd1;
            if (push_eff) wr_ptr <= wr_ptr + 1'b1;
            if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !push_eff) overflow <= 1'b1;
            // Held state follows the decoded event even when the FIFO drops it.
            if (push_req && (key_hit != '0)) begin
                if (push_ev[8]) held <= held & ~key_hit;
                else            held <= held | key_hit;
            end
            if (bus.CODE_VALID && bus.CODE_ERR && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_eff) mem[wr_ptr[AW-1:0]] <= push_ev;
    end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomized and directed bench for ps2_scancode_decoder against a queue-based
// reference model built from the decoding rules.
module tb_ps2_scancode_decoder;
    localparam int          DEPTH = 4;
    localparam logic [15:0] TMO   = 16'd40;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] held;
    logic       overflow;
    logic [7:0] err_count;

    ps2_scancode_decoder_if bus ();

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .held      (held),
        .overflow  (overflow),
        .err_count (err_count)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [9:0] m_q[$];
    bit         m_ext, m_brk;
    int         m_gap;
    logic [4:0] m_held;
    bit         m_ovf;
    int         m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int key_idx(input bit ext, input logic [7:0] c);
        if (ext && c == 8'h75) return 0;
        if (ext && c == 8'h72) return 1;
        if (ext && c == 8'h6B) return 2;
        if (ext && c == 8'h74) return 3;
        if (!ext && c == 8'h29) return 4;
        return -1;
    endfunction

    task automatic model_edge(input bit v, input logic [7:0] c, input bit e, input bit p, input bit r);
        bit         do_push;
        bit         pop_ok;
        logic [9:0] ev;
        int         k;
        if (r) begin
            m_q.delete();
            m_ext = 0; m_brk = 0; m_gap = 0;
            m_held = '0; m_ovf = 0; m_err = 0;
            return;
        end
        do_push = 0;
        ev      = '0;
        pop_ok  = p && (m_q.size() > 0);
        if (v) begin
            m_gap = 0;
            if (e) begin
                if (m_err < 255) m_err++;
                m_ext = 0; m_brk = 0;
            end else if ((c == 8'hE0 || c == 8'hF0) && m_brk) begin
                m_ext = 0; m_brk = 0;
            end else if (c == 8'hE0) begin
                m_ext = 1;
            end else if (c == 8'hF0) begin
                m_brk = 1;
            end else if (!m_ext && !m_brk &&
                         (c == 8'hAA || c == 8'hFA || c == 8'hFE || c == 8'h00 || c == 8'hFF)) begin
                do_push = 0;
            end else begin
                do_push = 1;
                ev      = {m_ext, m_brk, c};
                m_ext = 0; m_brk = 0;
            end
        end else begin
            m_gap++;
            if (m_gap >= int'(TMO)) begin
                m_ext = 0; m_brk = 0;
            end
        end
        if (pop_ok) void'(m_q.pop_front());
        if (do_push) begin
            k = key_idx(ev[9], ev[7:0]);
            if (k >= 0) m_held[k] = !ev[8];
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else                    m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        chk("ev_valid", bus.ev_valid, m_q.size() > 0);
        if (m_q.size() > 0) chk("ev_data", bus.ev_data, m_q[0]);
        chk("held", held, m_held);
        chk("overflow", overflow, m_ovf);
        chk("err_count", err_count, m_err);
    endtask

    task automatic step(input bit v, input logic [7:0] c, input bit e, input bit p, input bit r);
        @(negedge CLK);
        bus.CODE_VALID = v;
        bus.CODE       = c;
        bus.CODE_ERR   = e;
        bus.ev_pop     = p;
        RST            = r;
        @(posedge CLK);
        model_edge(v, c, e, p, r);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0);
    endtask

    task automatic send(input logic [7:0] c);
        step(1, c, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(0, 8'h00, 0, 1, 0);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] pool [10];
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'hAA, 8'h00, 8'h1C};
        if ($urandom_range(0, 9) < 8) return pool[$urandom_range(0, 9)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        bus.CODE_VALID = 0; bus.CODE = '0; bus.CODE_ERR = 0; bus.ev_pop = 0; RST = 1;
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h1C, 0, 0, 1);
        chk("rst_ev_valid", bus.ev_valid, 0);
        chk("rst_held", held, 0);

        // space make then break, bytes 20 cycles apart
        send(8'h29); idle(19); send(8'hF0); idle(19); send(8'h29);
        chk("space_head", bus.ev_data, 10'h029);
        chk("space_held", held[4], 0);
        step(0, 8'h00, 0, 1, 0);
        chk("space_brk", bus.ev_data, 10'h129);
        drain();

        // extended UP make/break, then bare 75
        send(8'hE0); send(8'h75);
        chk("up_held", held[0], 1);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h75);
        chk("up_released", held[0], 0);
        drain();

        // overflow then simultaneous pop+push while full
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        chk("ovf_set", overflow, 1);
        chk("ovf_head", bus.ev_data, 10'h01C);
        step(1, 8'h1B, 0, 1, 0);
        chk("full_poppush_head", bus.ev_data, 10'h032);
        drain();

        // timeout boundary: one short of TIMEOUT keeps the prefix, TIMEOUT drops it
        send(8'hE0); idle(int'(TMO) - 1); send(8'h6B);
        chk("tmo_minus1_held", held[2], 1);
        send(8'hE0); send(8'hF0); idle(int'(TMO)); send(8'h6B);
        chk("tmo_held", held[2], 1);
        drain();

        // error byte cancels prefix; error counter saturates
        send(8'hE0); step(1, 8'hE0, 1, 0, 0); send(8'h74);
        chk("err_one", err_count, 1);
        chk("err_nonext", bus.ev_data, 10'h074);
        for (int i = 0; i < 300; i++) step(1, 8'($urandom_range(0, 255)), 1, 0, 0);
        chk("err_sat", err_count, 8'hFF);
        drain();

        // reset mid-prefix
        send(8'hE0); step(0, 8'h00, 0, 0, 1); send(8'h72);
        chk("rst_mid_ev", bus.ev_data, 10'h072);
        chk("rst_mid_held", held, 0);
        drain();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                idle(int'(TMO) - 2 + $urandom_range(0, 4));
            end else begin
                step($urandom_range(0, 99) < 35, rand_byte(), $urandom_range(0, 99) < 4,
                     $urandom_range(0, 99) < 30, $urandom_range(0, 999) < 5);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
